// File: rtl/gb_write_logger.sv
// gb_write_logger: traces GameBoy CPU bus writes inside an address window.
// Each qualified write becomes a timestamped record in a FIFO.
// Records are streamed out as 7-byte packets over a valid/ready byte interface.
module gb_write_logger #(
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned FIFO_LOG2 = 4,
    parameter logic [15:0] ADDR_LO   = 16'h0000,
    parameter logic [15:0] ADDR_HI   = 16'hffff
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 tick,
    input  logic [14:0]          adr,
    input  logic                 n_cs,
    input  logic                 n_write,
    input  logic [7:0]           data_in,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;

    typedef enum logic {IDLE, SEND} state_t;

    logic [14:0]          s_adr;
    logic                 s_ncs;
    logic                 s_nwr;
    logic [7:0]           s_data;
    logic [15:0]          s_addr;
    logic [23:0]          ts;
    logic [3:0]           low_cnt;
    logic                 armed;
    logic                 qualify;
    logic                 in_window;
    logic [16:0]          diff_lo;
    logic [16:0]          diff_hi;
    logic                 cap_valid;
    logic [47:0]          cap_rec;
    logic [47:0]          mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic                 lost_flag;
    state_t               state;
    logic [2:0]           idx;
    logic [47:0]          cur;

    function automatic logic [7:0] rec_byte(input logic [47:0] r, input logic [2:0] i);
        case (i)
            3'd1:    rec_byte = r[47:40];
            3'd2:    rec_byte = r[39:32];
            3'd3:    rec_byte = r[31:24];
            3'd4:    rec_byte = r[23:16];
            3'd5:    rec_byte = r[15:8];
            default: rec_byte = r[7:0];
        endcase
    endfunction

    // Extra sampling stage on the already IO-registered bus pins
    always_ff @(posedge clk) begin
        s_adr  <= adr;
        s_ncs  <= n_cs;
        s_nwr  <= n_write;
        s_data <= data_in;
    end

    assign s_addr  = {s_ncs, s_adr};
    // Window test via the borrow bit of 17-bit differences, which stays
    // meaningful even when a bound sits at the edge of the address space.
    assign diff_lo   = {1'b0, s_addr} - {1'b0, ADDR_LO};
    assign diff_hi   = {1'b0, ADDR_HI} - {1'b0, s_addr};
    assign in_window = !diff_lo[16] && !diff_hi[16];
    assign qualify   = armed && !s_nwr && (low_cnt == 4'(SETTLE - 1));

    // GameBoy clock-tick timestamp
    always_ff @(posedge clk) begin
        if (!n_reset)
            ts <= '0;
        else if (tick)
            ts <= ts + 24'd1;
    end

    // Write qualifier: arms on a high sample, captures once when the low run reaches SETTLE
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            armed     <= 1'b0;
            low_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_rec   <= '0;
        end else begin
            cap_valid <= qualify && in_window;
            if (qualify)
                cap_rec <= {ts, s_addr, s_data};
            if (s_nwr) begin
                armed   <= 1'b1;
                low_cnt <= '0;
            end else if (low_cnt != 4'(SETTLE)) begin
                low_cnt <= low_cnt + 4'd1;
            end
        end
    end

    assign full    = (count == (FIFO_LOG2+1)'(DEPTH));
    assign pop     = (count != '0) &&
                     ((state == IDLE) || (out_valid && out_ready && idx == 3'd6));
    assign push_ok = cap_valid && (!full || pop);
    assign drop    = cap_valid && full && !pop;

    // Record storage (no reset needed; occupancy is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= cap_rec;
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign fifo_level = count;

    // Serializer FSM: emits sync, ts[23:0], addr[15:0], data with registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
            cur       <= '0;
            lost_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur       <= mem[rd_ptr];
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= lost_flag ? 8'hA6 : 8'hA5;
                        lost_flag <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx != 3'd6) begin
                            idx      <= idx + 3'd1;
                            out_data <= rec_byte(cur, idx + 3'd1);
                        end else if (pop) begin
                            cur       <= mem[rd_ptr];
                            idx       <= '0;
                            out_data  <= lost_flag ? 8'hA6 : 8'hA5;
                            lost_flag <= 1'b0;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A drop in the same cycle as a load belongs to a later record
            if (drop)
                lost_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gb_write_logger.sv
// Self-checking bench for gb_write_logger: byte-stream scoreboard fed by a
// write-level reference model, plus directed latency/overflow/reset checks.
module tb_gb_write_logger;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        n_reset, tick, n_cs, n_write, out_ready;
    logic [14:0] adr;
    logic [7:0]  data_in;
    logic [7:0]  od0, od1, dc0, dc1;
    logic        ov0, ov1;
    logic [4:0]  fl0, fl1;

    always #5 clk = ~clk;

    gb_write_logger #(.SETTLE(SETTLE), .FIFO_LOG2(4), .ADDR_LO(16'h0000), .ADDR_HI(16'hffff)) u_dut (
        .clk(clk), .n_reset(n_reset), .tick(tick), .adr(adr), .n_cs(n_cs), .n_write(n_write),
        .data_in(data_in), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .fifo_level(fl0), .drop_cnt(dc0));

    gb_write_logger #(.SETTLE(SETTLE), .FIFO_LOG2(4), .ADDR_LO(16'h8000), .ADDR_HI(16'hffff)) u_win (
        .clk(clk), .n_reset(n_reset), .tick(tick), .adr(adr), .n_cs(n_cs), .n_write(n_write),
        .data_in(data_in), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .fifo_level(fl1), .drop_cnt(dc1));

    int          total = 0;
    int          bad = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [23:0] tick_total = '0;
    int          cyc = 0;
    int          last_low_cyc = 0;
    int          first_valid_cyc = -1;
    int          peak1 = 0;
    int          acc0 = 0;
    int          acc1 = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard the accept happening at the coming edge, then advance.
    task automatic step(input bit tk);
        tick = tk;
        if (rand_ready) out_ready = ($urandom % 8) != 0;
        if (n_reset) begin
            if (first_valid_cyc < 0 && ov0) first_valid_cyc = cyc;
            if (int'(fl1) > peak1) peak1 = int'(fl1);
            if (ov0 && out_ready) begin
                acc0++;
                check("q0_has_byte", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) check("byte0", od0, q0.pop_front());
            end
            if (ov1 && out_ready) begin
                acc1++;
                check("q1_has_byte", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) check("byte1", od1, q1.pop_front());
            end
            tick_total += 24'(tk);
        end else begin
            tick_total = '0;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void push_rec(input logic [47:0] r, input logic [7:0] sync,
                                     input bit to0, input bit to1);
        logic [7:0] b[7];
        b[0] = sync;         b[1] = r[47:40]; b[2] = r[39:32]; b[3] = r[31:24];
        b[4] = r[23:16];     b[5] = r[15:8];  b[6] = r[7:0];
        for (int i = 0; i < 7; i++) begin
            if (to0) q0.push_back(b[i]);
            if (to1) q1.push_back(b[i]);
        end
    endfunction

    // tmode: 0 no ticks, 1 tick every cycle, 2 random ticks
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int len,
                            input int tmode, output logic [47:0] rec, output bit cap);
        logic [23:0] ts_exp;
        bit          tk;
        ts_exp  = '0;
        n_write = 1'b1;
        step(tmode == 1);
        adr     = a[14:0];
        n_cs    = a[15];
        data_in = d;
        for (int i = 0; i < len; i++) begin
            n_write = 1'b0;
            if (i == 0) last_low_cyc = cyc;
            tk = (tmode == 1) ? 1'b1 : (tmode == 2) ? 1'($urandom % 2) : 1'b0;
            step(tk);
            // Timestamp seen by the capture: ticks through the SETTLE-th low sample's edge
            if (i == SETTLE - 1) ts_exp = tick_total;
        end
        n_write = 1'b1;
        cap = (len >= SETTLE);
        rec = {ts_exp, a, d};
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int len, input int tmode);
        logic [47:0] r;
        bit          c;
        do_write(a, d, len, tmode, r, c);
        if (c) push_rec(r, 8'hA5, 1'b1, a >= 16'h8000);
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n_write    = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            step(1'b0);
            n++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        repeat (3) step(1'b0);
    endtask

    initial begin
        logic [47:0] recs[19];
        bit          c;
        int          s0, s1, n;

        n_reset = 1'b0; tick = 1'b0; n_write = 1'b1; adr = '0; n_cs = 1'b0;
        data_in = '0; out_ready = 1'b1;
        @(negedge clk);
        step(1'b0);
        step(1'b0);
        n_reset = 1'b1;
        check("rst_valid", ov0, 0);
        check("rst_data", od0, 0);
        check("rst_level", fl0, 0);
        check("rst_drop", dc0, 0);

        // 1: five ticks, then 5A @ FF50 held 4 clocks
        repeat (5) step(1'b1);
        first_valid_cyc = -1;
        do_write(16'hFF50, 8'h5A, 4, 0, recs[0], c);
        for (int i = 0; i < 2; i++) begin
            q0.push_back(8'hA5); q0.push_back(8'h00); q0.push_back(8'h00); q0.push_back(8'h05);
            q0.push_back(8'hFF); q0.push_back(8'h50); q0.push_back(8'h5A);
        end
        // both instances see FF50; move the second copy to the windowed scoreboard
        repeat (7) q1.push_back(q0.pop_back());
        q1.reverse();
        drain();
        check("t1_latency", first_valid_cyc - last_low_cyc, 5);

        // 2: 1-clock glitch ignored, then a real write
        s0 = acc0;
        wr(16'h1234, 8'h77, 1, 0);
        wr(16'hC000, 8'h11, 3, 0);
        drain();
        check("t2_bytes", acc0 - s0, 7);

        // 3: windowed instance keeps only 9FFF
        peak1 = 0;
        s1 = acc1;
        wr(16'h2000, 8'h21, 2, 0);
        wr(16'h9FFF, 8'h9F, 2, 0);
        drain();
        check("t3_bytes1", acc1 - s1, 7);
        check("t3_peak1", peak1, 1);

        // 5: tick on every cycle, including the capture edge
        wr(16'hABCD, 8'hEF, 4, 1);
        drain();

        // random writes, random ticks, mostly-ready consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr(16'($urandom), 8'($urandom), $urandom_range(1, 5), 2);
            n_write = 1'b1;
            repeat ($urandom_range(6, 10)) step(1'($urandom % 2));
        end
        drain();
        check("rand_drop0", dc0, 0);
        check("rand_drop1", dc1, 0);

        // 4: consumer stalled, 19 writes. The first is popped into the serializer,
        // 16 fill the FIFO and the last two are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++)
            do_write(16'h8000 | 16'($urandom), 8'($urandom), 2, 2, recs[i], c);
        n_write = 1'b1;
        repeat (3) step(1'b0);
        check("t4_level0", fl0, 16);
        check("t4_drop0", dc0, 2);
        check("t4_level1", fl1, 16);
        check("t4_drop1", dc1, 2);
        check("t4_valid", ov0, 1);
        check("t4_sync", od0, 8'hA5);
        for (int i = 0; i < 17; i++)
            push_rec(recs[i], (i == 1) ? 8'hA6 : 8'hA5, 1'b1, 1'b1);
        drain();
        check("t4_drop_hold", dc0, 2);

        // 6: reset while byte idx3 is presented, ready toggling
        out_ready = 1'b0;
        wr(16'h8100, 8'h3C, 2, 0);
        wr(16'h8200, 8'h4D, 2, 0);
        repeat (3) step(1'b0);
        check("t6_level_pre", fl0, 1);
        s0 = acc0;
        n = 0;
        rand_ready = 1'b1;
        while (acc0 - s0 < 3 && n < 200) begin
            step(1'b0);
            n++;
        end
        rand_ready = 1'b0;
        check("t6_reach_idx3", acc0 - s0, 3);
        n_reset = 1'b0;
        n_write = 1'b0;
        adr = 15'h0123; n_cs = 1'b1; data_in = 8'h99;
        out_ready = 1'b1;
        step(1'b0);
        check("t6_valid0", ov0, 0);
        check("t6_level0", fl0, 0);
        check("t6_drop0", dc0, 0);
        check("t6_valid1", ov1, 0);
        check("t6_level1", fl1, 0);
        q0.delete();
        q1.delete();
        n_reset = 1'b1;
        repeat (4) step(1'b0);
        n_write = 1'b1;
        repeat (6) step(1'b0);
        check("t6_nolog_level", fl0, 0);
        check("t6_nolog_valid", ov0, 0);
        wr(16'h8300, 8'h5E, 2, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
